// File: rtl/wb_master_bridge_if.sv
// Wishbone master-side bus bundle for wb_master_bridge.
// Outputs toward the interconnect are *_o, returns from it are *_i.
interface wb_master_bus_t #(
  parameter int TAGSIZE = 1
);
  logic [31:0]        wb_adr_o;
  logic [31:0]        wb_dat_o;
  logic [3:0]         wb_sel_o;
  logic               wb_we_o;
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_lock_o;
  logic [TAGSIZE-1:0] wb_tgd_o;
  logic [TAGSIZE-1:0] wb_tga_o;
  logic [TAGSIZE-1:0] wb_tgc_o;
  logic [31:0]        wb_dat_i;
  logic [TAGSIZE-1:0] wb_tgd_i;
  logic               wb_ack_i;
  logic               wb_err_i;
  logic               wb_rty_i;
  logic               wb_gnt_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    output wb_cyc_o, wb_stb_o, wb_lock_o,
    output wb_tgd_o, wb_tga_o, wb_tgc_o,
    input  wb_dat_i, wb_tgd_i, wb_ack_i,
    input  wb_err_i, wb_rty_i, wb_gnt_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    input  wb_cyc_o, wb_stb_o, wb_lock_o,
    input  wb_tgd_o, wb_tga_o, wb_tgc_o,
    output wb_dat_i, wb_tgd_i, wb_ack_i,
    output wb_err_i, wb_rty_i, wb_gnt_i
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Valid/ready request -> single Wishbone master transaction bridge.
// Optional watchdog on the bus phase: define WB_BRIDGE_TIMEOUT_EN.
module wb_master_bridge #(
  parameter int TAGSIZE        = 1,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  wb_master_bus_t.master wb_master_bus
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BACKOFF,
    RSP
  } state_t;

  state_t        state_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [RW-1:0] retry_q;
  logic [31:0]   rsp_dat_q;
  logic          rsp_err_q;

  logic gnt;
  logic t_err;
  logic t_rty;
  logic t_ack;
  logic retry_max;
  logic wdog_hit;
  logic in_req;
  logic unused_tgd;

  // Response lines are shared, so only a granted cycle may terminate.
  assign gnt       = wb_master_bus.wb_gnt_i;
  assign t_err     = gnt & wb_master_bus.wb_err_i;
  assign t_rty     = gnt & wb_master_bus.wb_rty_i;
  assign t_ack     = gnt & wb_master_bus.wb_ack_i;
  assign retry_max = (retry_q == RW'(MAX_RETRY));

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog_q;
  assign wdog_hit = (wdog_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // Transaction FSM: latch request, run bus phase, hold response.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      retry_q   <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            sel_q   <= req_sel_i;
            retry_q <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            wdog_q  <= '0;
`endif
            state_q <= REQ;
          end
        end
        REQ: begin
`ifdef WB_BRIDGE_TIMEOUT_EN
          wdog_q <= wdog_q + 1'b1;
`endif
          if (t_err) begin
            rsp_err_q <= 1'b1;
            rsp_dat_q <= '0;
            state_q   <= RSP;
          end else if (t_rty) begin
            if (retry_max) begin
              rsp_err_q <= 1'b1;
              rsp_dat_q <= '0;
              state_q   <= RSP;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= BACKOFF;
            end
          end else if (t_ack) begin
            rsp_err_q <= 1'b0;
            rsp_dat_q <= we_q ? 32'd0
                              : wb_master_bus.wb_dat_i;
            state_q   <= RSP;
          end else if (wdog_hit) begin
            rsp_err_q <= 1'b1;
            rsp_dat_q <= '0;
            state_q   <= RSP;
          end
        end
        BACKOFF: begin
`ifdef WB_BRIDGE_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= REQ;
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state.
  assign in_req      = (state_q == REQ);
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

  // Bus drive: only the REQ state presents a cycle.
  assign wb_master_bus.wb_cyc_o  = in_req;
  assign wb_master_bus.wb_stb_o  = in_req;
  assign wb_master_bus.wb_we_o   = in_req & we_q;
  assign wb_master_bus.wb_adr_o  = in_req ? adr_q : 32'd0;
  assign wb_master_bus.wb_dat_o  = in_req ? dat_q : 32'd0;
  assign wb_master_bus.wb_sel_o  = in_req ? sel_q : 4'd0;
  assign wb_master_bus.wb_lock_o = 1'b0;
  assign wb_master_bus.wb_tgd_o  = '0;
  assign wb_master_bus.wb_tga_o  = '0;
  assign wb_master_bus.wb_tgc_o  = '0;

  assign unused_tgd = ^wb_master_bus.wb_tgd_i;

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter TAGSIZE, default 1, SHALL set the width of all Wishbone tag ports.
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the number of retries allowed after wb_rty_i before the bridge reports an error.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the watchdog limit (used only with WB_BRIDGE_TIMEOUT_EN).
REQ-004 The bridge SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-005 clk_i  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rstn_i  in  1  synchronous active-low reset.
REQ-007 req_valid_i  in  1  request present.
REQ-008 req_ready_o  out  1  request accepted when high together with req_valid_i.
REQ-009 req_we_i  in  1  1=write, 0=read.
REQ-010 req_adr_i  in  32  byte address.
REQ-011 req_dat_i  in  32  write data.
REQ-012 req_sel_i  in  4  byte lanes.
REQ-013 rsp_valid_o  out  1  response present.
REQ-014 rsp_ready_i  in  1  response consumed.
REQ-015 rsp_dat_o  out  32  read data; 0 for writes and errors.
REQ-016 rsp_err_o  out  1  transaction failed.
REQ-017 wb_master_bus  wb_master_bus_t  --  Wishbone master port to the interconnect: adr/dat/sel/we/cyc/stb/lock/tgd/tga/tgc out; dat/tgd/ack/err/rty/gnt in.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, BACKOFF and RSP.
REQ-019 req_ready_o SHALL equal (state==IDLE); the handshake SHALL latch we/adr/dat/sel and move to REQ, clearing the retry and watchdog counters.
REQ-020 In REQ, wb_cyc_o and wb_stb_o SHALL be 1 and adr/dat/sel/we SHALL show the latched values, held stable until termination; in every other state cyc, stb, adr, dat, sel and we SHALL be 0.
REQ-021 Bus termination SHALL be recognised only when wb_gnt_i=1; ack/err/rty seen while wb_gnt_i=0 SHALL be ignored, because the response lines are shared by all masters.
REQ-022 When several termination inputs are high together, priority SHALL be err > rty > ack.
REQ-023 On granted ack the bridge SHALL move to RSP: rsp_dat_o = wb_dat_i for reads and 0 for writes; rsp_err_o = 0.
REQ-024 On granted err the bridge SHALL move to RSP with rsp_err_o=1 and rsp_dat_o=0.
REQ-025 On granted rty with retry count < MAX_RETRY, the bridge SHALL increment the count and move to BACKOFF.
REQ-026 On granted rty with retry count == MAX_RETRY, the bridge SHALL move to RSP with rsp_err_o=1.
REQ-027 BACKOFF SHALL last exactly one cycle with cyc=0, releasing the bus for arbitration, then return to REQ.
REQ-028 cyc and stb SHALL deassert on the clock edge that samples termination; the minimum latency from accept to rsp_valid_o is 2 cycles.
REQ-029 In RSP, rsp_valid_o SHALL be 1 and rsp_dat_o/rsp_err_o SHALL be held until rsp_ready_i=1; the bridge SHALL then return to IDLE.
REQ-030 A new request SHALL NOT be accepted in the cycle the response is consumed; at most one transaction SHALL be outstanding.
REQ-031 wb_lock_o and tgd/tga/tgc outputs SHALL be driven 0.

Reset
REQ-032 With rstn_i=0 at a clock edge, the state SHALL become IDLE, both counters 0, and every output 0 except req_ready_o, which SHALL be 1 after reset.
REQ-033 A reset during REQ, BACKOFF or RSP SHALL drop cyc/stb on that edge and discard the transaction without producing a response.

Configuration
REQ-034 With macro WB_BRIDGE_TIMEOUT_EN defined, a watchdog SHALL count every cycle in REQ, whether granted or not; when it reaches TIMEOUT_CYCLES without a granted termination, the bridge SHALL go to RSP with rsp_err_o=1, and the watchdog SHALL restart on each REQ entry.
REQ-035 Without WB_BRIDGE_TIMEOUT_EN, the watchdog logic SHALL be absent, TIMEOUT_CYCLES SHALL be ignored, and REQ SHALL wait indefinitely.

Verification
REQ-036 Read 0x100 with gnt=1 and ack one cycle after cyc, wb_dat_i=0xDEADBEEF -> rsp_valid_o 2 cycles after accept, rsp_dat_o=0xDEADBEEF, rsp_err_o=0.
REQ-037 Write with wb_gnt_i=0 for 5 cycles and ack pulsed during that time, then gnt=1 with ack -> early acks ignored; single response rsp_err_o=0, rsp_dat_o=0.
REQ-038 With MAX_RETRY=3, rty returned on every attempt -> 4 bus attempts, each separated by one cyc=0 cycle, then rsp_err_o=1.
REQ-039 err and ack high together while granted -> rsp_err_o=1; rsp_ready_i held 0 for 3 cycles -> response held stable; req_ready_o=0 until IDLE.
REQ-040 With WB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no termination -> rsp_err_o=1 after 8 REQ cycles; rstn_i=0 mid-REQ -> cyc=0 next edge and no response.
